// File: rtl/msi_pkg.sv
// Shared definitions for the MSI snooping bus: bus op codes, cache-line states
// and the memory-side responder's FSM encoding.
package msi_pkg;

    typedef enum logic [1:0] {
        OP_RD_MISS = 2'b00,
        OP_WR_MISS = 2'b01,
        OP_INVAL   = 2'b10,
        OP_WB      = 2'b11
    } bus_op_t;

    // Line states used by the cache-side sm_cpu/sm_bus controllers
    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_state_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNOOP  = 3'd1,
        ST_WB     = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_RESP   = 3'd5
    } resp_state_t;

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with a zero flag; times both the memory read latency
// and the snoop timeout window.
module bus_wait_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/msi_bus_responder.sv
// Memory-side responder for the MSI snooping bus: one request at a time,
// snoop broadcast, owner write-back and memory read/write sequencing.
module msi_bus_responder
    import msi_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int MEM_LAT  = 2,
    parameter int SNOOP_TO = 7
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              snoop_valid,
    output logic [1:0]        snoop_op,
    output logic [ADDR_W-1:0] snoop_addr,
    input  logic              snoop_done,
    input  logic              snoop_wb,
    input  logic              snoop_abort,
    input  logic [DATA_W-1:0] snoop_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_src,
    output logic              proto_err,
    output logic [2:0]        state
);

    localparam int MAX_WAIT = (MEM_LAT > SNOOP_TO) ? MEM_LAT : SNOOP_TO;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    resp_state_t       state_reg;
    bus_op_t           op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic              wb_bad_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic              resp_src_reg;
    logic              proto_err_reg;

    logic              cnt_load;
    logic              cnt_dec;
    logic [CNT_W-1:0]  cnt_load_value;
    logic              cnt_zero;

    bus_wait_counter #(.W(CNT_W)) wait_cnt (
        .clock      (clock),
        .resetn     (resetn),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (cnt_load_value),
        .zero       (cnt_zero)
    );

    // Loading with N-1 makes the zero flag mark the last cycle of an N-cycle wait.
    // The MEM_LAT reload on leaving SNOOP/WB is harmless when MEM_RD is not next.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        cnt_load_value = CNT_W'(MEM_LAT - 1);
        case (state_reg)
            ST_IDLE: begin
                if (req_valid && (req_op != OP_WB)) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(SNOOP_TO - 1);
                end
            end
            ST_SNOOP: begin
                if (snoop_done || cnt_zero) cnt_load = 1'b1;
                else                        cnt_dec  = 1'b1;
            end
            ST_WB:     cnt_load = 1'b1;
            ST_MEM_RD: cnt_dec  = !cnt_zero;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_RD_MISS;
            addr_reg      <= '0;
            data_reg      <= '0;
            wb_data_reg   <= '0;
            wb_bad_reg    <= 1'b0;
            resp_data_reg <= '0;
            resp_src_reg  <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg        <= bus_op_t'(req_op);
                        addr_reg      <= req_addr;
                        data_reg      <= req_data;
                        wb_bad_reg    <= 1'b0;
                        resp_data_reg <= '0;
                        resp_src_reg  <= 1'b0;
                        state_reg     <= (req_op == OP_WB) ? ST_MEM_WR : ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    if (snoop_done) begin
                        if (snoop_abort && !snoop_wb) proto_err_reg <= 1'b1;
                        if (op_reg == OP_INVAL) begin
                            state_reg <= ST_RESP;
                        end else if (snoop_wb) begin
                            // A write-back without abort is still committed, but memory answers.
                            wb_data_reg <= snoop_data;
                            wb_bad_reg  <= !snoop_abort;
                            if (!snoop_abort) proto_err_reg <= 1'b1;
                            state_reg   <= ST_WB;
                        end else begin
                            state_reg <= ST_MEM_RD;
                        end
                    end else if (cnt_zero) begin
                        proto_err_reg <= 1'b1;
                        state_reg     <= (op_reg == OP_INVAL) ? ST_RESP : ST_MEM_RD;
                    end
                end
                ST_WB: begin
                    if (wb_bad_reg) begin
                        state_reg <= ST_MEM_RD;
                    end else begin
                        resp_data_reg <= wb_data_reg;
                        resp_src_reg  <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_MEM_RD: begin
                    if (cnt_zero) begin
                        resp_data_reg <= mem_rdata;
                        resp_src_reg  <= 1'b0;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_MEM_WR: state_reg <= ST_RESP;
                ST_RESP:   state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_reg == ST_IDLE);
    assign snoop_valid = (state_reg == ST_SNOOP);
    assign snoop_op    = op_reg;
    assign snoop_addr  = addr_reg;
    assign mem_addr    = addr_reg;
    assign mem_wren    = (state_reg == ST_WB) || (state_reg == ST_MEM_WR);
    assign mem_wdata   = (state_reg == ST_WB)     ? wb_data_reg :
                         (state_reg == ST_MEM_WR) ? data_reg    : '0;
    assign resp_valid  = (state_reg == ST_RESP);
    assign resp_data   = resp_data_reg;
    assign resp_src    = resp_src_reg;
    assign proto_err   = proto_err_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_msi_bus_responder.sv
// Directed vector bench for msi_bus_responder with a simple memory model and
// a scripted snooper.
module tb_msi_bus_responder;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic       snoop_valid;
    logic [1:0] snoop_op;
    logic [2:0] snoop_addr;
    logic       snoop_done;
    logic       snoop_wb;
    logic       snoop_abort;
    logic [7:0] snoop_data;
    logic [2:0] mem_addr;
    logic       mem_wren;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_src;
    logic       proto_err;
    logic [2:0] state;

    always #5 clock = ~clock;

    msi_bus_responder #(.ADDR_W(3), .DATA_W(8), .MEM_LAT(2), .SNOOP_TO(7)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .snoop_valid (snoop_valid),
        .snoop_op    (snoop_op),
        .snoop_addr  (snoop_addr),
        .snoop_done  (snoop_done),
        .snoop_wb    (snoop_wb),
        .snoop_abort (snoop_abort),
        .snoop_data  (snoop_data),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_src    (resp_src),
        .proto_err   (proto_err),
        .state       (state)
    );

    logic [7:0] mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h5A, 8'h16, 8'h17};
    assign mem_rdata = mem[mem_addr];
    always @(posedge clock) if (mem_wren) mem[mem_addr] <= mem_wdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] addr;
        logic [7:0] data;
        int         done_at;     // SNOOP cycle that carries snoop_done; 0 = never
        logic       wb;
        logic       abort;
        logic [7:0] sdata;
        int         exp_lat;     // cycle index of resp_valid after the acceptance edge
        logic [7:0] exp_rdata;
        logic       exp_src;
        int         exp_wrens;
        logic [7:0] exp_wdata;
        int         exp_snoops;
        logic       exp_perr;
        logic       reset_after;
    } vec_t;

    vec_t vecs[12];

    task automatic apply_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", req_ready, 1);
        check("rst_state", state, 0);
        check("rst_proto_err", proto_err, 0);
        resetn = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int snoops = 0;
        int wrens = 0;
        int lat = 0;
        logic [7:0] wdata = 8'h00;
        logic [2:0] waddr = 3'd0;
        logic [7:0] rdata = 8'h00;
        logic src = 1'b0;
        logic got = 1'b0;
        @(negedge clock);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_data  = v.data;
        @(posedge clock);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            req_valid   = 1'b0;
            snoop_done  = 1'b0;
            snoop_wb    = 1'b0;
            snoop_abort = 1'b0;
            snoop_data  = 8'h00;
            if (n == 1) check("busy_not_ready", req_ready, 0);
            if (snoop_valid) begin
                snoops++;
                if (snoops == 1) begin
                    check("snoop_op", snoop_op, v.op);
                    check("snoop_addr", snoop_addr, v.addr);
                end
                if (snoops == v.done_at) begin
                    snoop_done  = 1'b1;
                    snoop_wb    = v.wb;
                    snoop_abort = v.abort;
                    snoop_data  = v.sdata;
                end
            end
            if (mem_wren) begin
                wrens++;
                wdata = mem_wdata;
                waddr = mem_addr;
            end
            if (resp_valid) begin
                got   = 1'b1;
                lat   = n;
                rdata = resp_data;
                src   = resp_src;
                break;
            end
        end
        check("resp_seen", got, 1);
        check("latency", lat, v.exp_lat);
        check("resp_data", rdata, v.exp_rdata);
        check("resp_src", src, v.exp_src);
        check("wren_count", wrens, v.exp_wrens);
        if (v.exp_wrens > 0) begin
            check("wr_data", wdata, v.exp_wdata);
            check("wr_addr", waddr, v.addr);
        end
        check("snoop_cycles", snoops, v.exp_snoops);
        @(negedge clock);
        check("resp_one_cycle", resp_valid, 0);
        check("back_idle", state, 0);
        check("proto_err", proto_err, v.exp_perr);
        $display("txn %0d op=%0d addr=%0d lat=%0d data=%02h src=%0d wrens=%0d perr=%0d",
                 idx, v.op, v.addr, lat, rdata, src, wrens, proto_err);
        if (v.reset_after) apply_reset();
    endtask

    initial begin
        //          op     addr  data   done wb    ab    sdata  lat rdata  src wr wdata  sn perr  rst
        vecs[0]  = '{2'b00, 3'd5, 8'h00, 1, 1'b0, 1'b0, 8'h00, 4,  8'h5A, 0, 0, 8'h00, 1, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 3'd2, 8'h00, 1, 1'b1, 1'b1, 8'hC3, 3,  8'hC3, 1, 1, 8'hC3, 1, 1'b0, 1'b0};
        vecs[2]  = '{2'b11, 3'd7, 8'h11, 0, 1'b0, 1'b0, 8'h00, 2,  8'h00, 0, 1, 8'h11, 0, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 3'd7, 8'h00, 3, 1'b0, 1'b0, 8'h00, 6,  8'h11, 0, 0, 8'h00, 3, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 3'd2, 8'h00, 2, 1'b0, 1'b0, 8'h00, 3,  8'h00, 0, 0, 8'h00, 2, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 3'd2, 8'h00, 1, 1'b1, 1'b1, 8'h3C, 3,  8'h3C, 1, 1, 8'h3C, 1, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 3'd2, 8'h00, 1, 1'b0, 1'b0, 8'h00, 4,  8'h3C, 0, 0, 8'h00, 1, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 3'd6, 8'h00, 2, 1'b0, 1'b0, 8'h00, 5,  8'h16, 0, 0, 8'h00, 2, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 3'd5, 8'h00, 0, 1'b0, 1'b0, 8'h00, 10, 8'h5A, 0, 0, 8'h00, 7, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 3'd5, 8'h00, 1, 1'b0, 1'b0, 8'h00, 4,  8'h5A, 0, 0, 8'h00, 1, 1'b1, 1'b1};
        vecs[10] = '{2'b00, 3'd3, 8'h00, 1, 1'b1, 1'b0, 8'h77, 5,  8'h77, 0, 1, 8'h77, 1, 1'b1, 1'b1};
        vecs[11] = '{2'b00, 3'd5, 8'h00, 1, 1'b0, 1'b1, 8'hEE, 4,  8'h5A, 0, 0, 8'h00, 1, 1'b1, 1'b1};

        resetn      = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_addr    = 3'd0;
        req_data    = 8'h00;
        snoop_done  = 1'b0;
        snoop_wb    = 1'b0;
        snoop_abort = 1'b0;
        snoop_data  = 8'h00;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("init_ready", req_ready, 1);
        check("init_resp_valid", resp_valid, 0);
        check("init_mem_wren", mem_wren, 0);
        check("init_state", state, 0);
        check("init_snoop_valid", snoop_valid, 0);
        check("init_resp_data", resp_data, 0);
        check("init_proto_err", proto_err, 0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset while waiting on memory drops the read entirely
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 3'd5;
        @(posedge clock);
        @(negedge clock);
        req_valid  = 1'b0;
        snoop_done = 1'b1;
        @(negedge clock);
        snoop_done = 1'b0;
        check("mid_in_mem_rd", state, 3);
        resetn = 1'b0;
        @(negedge clock);
        check("mid_rst_state", state, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_wren", mem_wren, 0);
        resetn = 1'b1;
        $display("txn mid-op reset: state=%0d resp_valid=%0d", state, resp_valid);
        run_vec(vecs[0], 12);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
